// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: the line-graphics fetcher always wins, the CPU fills idle cycles
// via req/ack, writes are posted through a one-entry buffer, and the worst CPU wait is recorded.
module vram_arbiter #(
    parameter int WAIT_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              gfx_active,
    input  logic [13:0]       gfx_vaddr,
    output logic [15:0]       gfx_vdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [13:0]       cpu_addr,
    input  logic [15:0]       cpu_wrdata,
    input  logic [1:0]        cpu_bytesel,
    output logic              cpu_ack,
    output logic [15:0]       cpu_rddata,
    output logic [13:0]       ram_addr,
    output logic [15:0]       ram_wrdata,
    output logic [1:0]        ram_wren,
    input  logic [15:0]       ram_rddata,
    input  logic              stat_clr,
    output logic [WAIT_W-1:0] stat_maxwait
);

    // state  | meaning
    // S_IDLE | may drain the write buffer, issue a CPU read, or accept a CPU write
    // S_RD   | CPU read address is in the RAM; capture ram_rddata at the end of the cycle
    // S_ACK  | cpu_ack pulses for the completed read
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              buf_valid_q, buf_valid_d;
    logic [13:0]       buf_addr_q, buf_addr_d;
    logic [15:0]       buf_data_q, buf_data_d;
    logic [1:0]        buf_be_q, buf_be_d;
    logic              ack_q, ack_d;
    logic [15:0]       rddata_q, rddata_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [WAIT_W-1:0] maxwait_q, maxwait_d;

    logic              slot_free;
    logic              drain;
    logic              issue_rd;
    logic              accept_wr;
    logic [13:0]       slot_addr;
    logic [15:0]       slot_wrdata;
    logic [1:0]        slot_wren;

    // reset_n gates the slot so the RAM sees nothing from a held request while in reset
    assign slot_free = reset_n && (state_q == S_IDLE) && !gfx_active;
    assign drain     = slot_free && buf_valid_q;
    assign issue_rd  = slot_free && !buf_valid_q && cpu_req && !cpu_we && !ack_q;
    assign accept_wr = (state_q == S_IDLE) && cpu_req && cpu_we && !buf_valid_q && !ack_q;

    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        buf_be_d    = buf_be_q;
        ack_d       = 1'b0;
        rddata_d    = rddata_q;
        slot_addr   = '0;
        slot_wrdata = '0;
        slot_wren   = '0;

        case (state_q)
            S_IDLE: begin
                if (drain) begin
                    slot_addr   = buf_addr_q;
                    slot_wrdata = buf_data_q;
                    slot_wren   = buf_be_q;
                    buf_valid_d = 1'b0;
                end else if (issue_rd) begin
                    slot_addr = cpu_addr;
                    state_d   = S_RD;
                end
                if (accept_wr) begin
                    buf_valid_d = 1'b1;
                    buf_addr_d  = cpu_addr;
                    buf_data_d  = cpu_wrdata;
                    buf_be_d    = cpu_bytesel;
                    ack_d       = 1'b1;
                end
            end
            S_RD: begin
                slot_addr = cpu_addr;
                rddata_d  = ram_rddata;
                ack_d     = 1'b1;
                state_d   = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // On an ack the finished wait is folded into the maximum; a coincident clear keeps only it
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        maxwait_d  = maxwait_q;
        if (ack_q) begin
            wait_cnt_d = '0;
            if (stat_clr) begin
                maxwait_d = wait_cnt_q;
            end else if (wait_cnt_q > maxwait_q) begin
                maxwait_d = wait_cnt_q;
            end
        end else begin
            if (cpu_req && (wait_cnt_q != {WAIT_W{1'b1}})) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
            if (stat_clr) begin
                maxwait_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            buf_be_q    <= '0;
            ack_q       <= 1'b0;
            rddata_q    <= '0;
            wait_cnt_q  <= '0;
            maxwait_q   <= '0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            buf_be_q    <= buf_be_d;
            ack_q       <= ack_d;
            rddata_q    <= rddata_d;
            wait_cnt_q  <= wait_cnt_d;
            maxwait_q   <= maxwait_d;
        end
    end

    assign ram_addr     = gfx_active ? gfx_vaddr : slot_addr;
    assign ram_wren     = gfx_active ? 2'b00 : slot_wren;
    assign ram_wrdata   = slot_wrdata;
    assign gfx_vdata    = ram_rddata;
    assign cpu_ack      = ack_q;
    assign cpu_rddata   = rddata_q;
    assign stat_maxwait = maxwait_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter with a behavioural RAM and an abstract
// reference model of memory contents, ack timing and worst-case wait.
module tb_vram_arbiter;

    logic        clk;
    logic        reset_n;
    logic        gfx_active;
    logic [13:0] gfx_vaddr;
    logic [15:0] gfx_vdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [15:0] cpu_wrdata;
    logic [1:0]  cpu_bytesel;
    logic        cpu_ack;
    logic [15:0] cpu_rddata;
    logic [13:0] ram_addr;
    logic [15:0] ram_wrdata;
    logic [1:0]  ram_wren;
    logic [15:0] ram_rddata;
    logic        stat_clr;
    logic [7:0]  stat_maxwait;

    logic [15:0] vram    [0:16383];
    logic [15:0] ref_mem [0:16383];
    logic        pre_we;
    logic [13:0] pre_addr;
    logic [15:0] pre_data;

    int          n_checks;
    int          n_pass;
    int          model_max;
    logic        pend;

    vram_arbiter #(.WAIT_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .gfx_active   (gfx_active),
        .gfx_vaddr    (gfx_vaddr),
        .gfx_vdata    (gfx_vdata),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wrdata   (cpu_wrdata),
        .cpu_bytesel  (cpu_bytesel),
        .cpu_ack      (cpu_ack),
        .cpu_rddata   (cpu_rddata),
        .ram_addr     (ram_addr),
        .ram_wrdata   (ram_wrdata),
        .ram_wren     (ram_wren),
        .ram_rddata   (ram_rddata),
        .stat_clr     (stat_clr),
        .stat_maxwait (stat_maxwait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous-read RAM with byte enables; pre_we is a load port for preloading
    always @(posedge clk) begin
        if (pre_we) begin
            vram[pre_addr] <= pre_data;
        end else begin
            if (ram_wren[0]) vram[ram_addr][7:0]  <= ram_wrdata[7:0];
            if (ram_wren[1]) vram[ram_addr][15:8] <= ram_wrdata[15:8];
        end
        ram_rddata <= vram[ram_addr];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // one CPU transaction; gfx_hold >= 0 keeps gfx_active high for that many cycles, -1 randomises it
    task automatic cpu_access(input logic we, input logic [13:0] a, input logic [15:0] d,
                              input logic [1:0] be, input int gfx_hold,
                              output logic [15:0] rd, output int lat);
        int          exp_ack;
        logic        need_drain;
        logic        g;
        logic [13:0] ga;
        logic        prev_g;
        logic [13:0] prev_ga;
        int          w;
        exp_ack    = (we && !pend) ? 1 : -1;
        need_drain = pend;
        lat        = -1;
        rd         = '0;
        prev_g     = 1'b0;
        prev_ga    = '0;
        cpu_req     = 1'b1;
        cpu_we      = we;
        cpu_addr    = a;
        cpu_wrdata  = d;
        cpu_bytesel = be;
        for (int k = 0; k < 600 && lat < 0; k++) begin
            if (gfx_hold < 0) g = 1'($urandom_range(0, 1));
            else              g = (k < gfx_hold);
            ga = 14'($urandom);
            gfx_active = g;
            gfx_vaddr  = ga;
            if (!g && exp_ack < 0) begin
                if (need_drain) begin
                    need_drain = 1'b0;
                    if (we) exp_ack = k + 2;
                end else if (!we) begin
                    exp_ack = k + 2;
                end
            end
            @(negedge clk);
            n_checks++;
            if (cpu_ack !== (k == exp_ack))
                $display("FAIL ack_timing k=%0d got=%b expected=%b", k, cpu_ack, (k == exp_ack));
            else n_pass++;
            if (g) begin
                n_checks++;
                if (ram_addr !== ga || ram_wren !== 2'b00)
                    $display("FAIL gfx_mux addr=%h wren=%b required addr=%h wren=00", ram_addr, ram_wren, ga);
                else n_pass++;
            end
            if (prev_g) begin
                n_checks++;
                if (gfx_vdata !== vram[prev_ga])
                    $display("FAIL gfx_vdata got=%h expected=%h", gfx_vdata, vram[prev_ga]);
                else n_pass++;
            end
            if (cpu_ack) begin
                lat  = k;
                rd   = cpu_rddata;
                pend = we && g;
            end
            prev_g  = g;
            prev_ga = ga;
            next_cycle();
        end
        cpu_req    = 1'b0;
        gfx_active = 1'b0;
        if (lat < 0) begin
            n_checks++;
            $display("FAIL ack_timeout addr=%h got no ack required an ack", a);
        end else begin
            w = (lat > 255) ? 255 : lat;
            if (w > model_max) model_max = w;
            if (!we) begin
                n_checks++;
                if (rd !== ref_mem[a])
                    $display("FAIL read_data addr=%h got=%h expected=%h", a, rd, ref_mem[a]);
                else n_pass++;
            end
        end
        if (we) begin
            if (be[0]) ref_mem[a][7:0]  = d[7:0];
            if (be[1]) ref_mem[a][15:8] = d[15:8];
        end
    endtask

    task automatic check_maxwait(input string name);
        @(negedge clk);
        n_checks++;
        if (stat_maxwait !== 8'(model_max))
            $display("FAIL %s got=%0d expected=%0d", name, stat_maxwait, model_max);
        else n_pass++;
        next_cycle();
        pend = 1'b0;
    endtask

    task automatic test_reset();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 14'h155;
        @(negedge clk);
        n_checks++;
        if (cpu_ack !== 1'b0 || cpu_rddata !== 16'h0)
            $display("FAIL reset_cpu ack=%b rddata=%h required 0/0000", cpu_ack, cpu_rddata);
        else n_pass++;
        n_checks++;
        if (ram_addr !== 14'h0 || ram_wren !== 2'b00 || ram_wrdata !== 16'h0)
            $display("FAIL reset_ram addr=%h wren=%b wrdata=%h required zeros", ram_addr, ram_wren, ram_wrdata);
        else n_pass++;
        n_checks++;
        if (stat_maxwait !== 8'h0)
            $display("FAIL reset_maxwait got=%0d expected=0", stat_maxwait);
        else n_pass++;
        next_cycle();
        gfx_active = 1'b1;
        gfx_vaddr  = 14'h2A5A;
        @(negedge clk);
        n_checks++;
        if (ram_addr !== 14'h2A5A)
            $display("FAIL reset_gfx_addr got=%h expected=2a5a", ram_addr);
        else n_pass++;
        next_cycle();
        gfx_active = 1'b0;
        cpu_req    = 1'b0;
        reset_n    = 1'b1;
        next_cycle();
    endtask

    task automatic test_idle_read();
        logic [15:0] rd;
        int          lat;
        cpu_access(1'b0, 14'h0123, 16'h0, 2'b00, 0, rd, lat);
        n_checks++;
        if (lat !== 2 || rd !== 16'hBEEF)
            $display("FAIL idle_read lat=%0d data=%h required lat=2 data=beef", lat, rd);
        else n_pass++;
        check_maxwait("idle_read_maxwait");
    endtask

    task automatic test_posted_write();
        logic [15:0] rd;
        logic [15:0] exp;
        int          lat;
        exp = {ref_mem[14'h0010][15:8], 8'h34};
        cpu_access(1'b1, 14'h0010, 16'h1234, 2'b01, 0, rd, lat);
        n_checks++;
        if (lat !== 1) $display("FAIL write_ack_lat got=%0d expected=1", lat);
        else n_pass++;
        n_checks++;
        if (vram[14'h0010] !== exp)
            $display("FAIL write_merge ram=%h expected=%h", vram[14'h0010], exp);
        else n_pass++;
        cpu_access(1'b0, 14'h0010, 16'h0, 2'b00, 0, rd, lat);
        n_checks++;
        if (lat !== 2 || rd !== exp)
            $display("FAIL read_after_write lat=%0d data=%h required lat=2 data=%h", lat, rd, exp);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd;
        int          lat;
        cpu_access(1'b1, 14'h0020, 16'hA5C3, 2'b11, 5, rd, lat);
        cpu_access(1'b1, 14'h0021, 16'h5A3C, 2'b10, 3, rd, lat);
        n_checks++;
        if (lat !== 5) $display("FAIL back_to_back_lat got=%0d expected=5", lat);
        else n_pass++;
        cpu_access(1'b0, 14'h0020, 16'h0, 2'b00, 0, rd, lat);
        cpu_access(1'b0, 14'h0021, 16'h0, 2'b00, 0, rd, lat);
        check_maxwait("back_to_back_maxwait");
    endtask

    task automatic test_gfx_priority();
        logic [15:0] rd;
        int          lat;
        cpu_access(1'b0, 14'h0123, 16'h0, 2'b00, 50, rd, lat);
        n_checks++;
        if (lat !== 52 || rd !== 16'hBEEF)
            $display("FAIL gfx_priority lat=%0d data=%h required lat=52 data=beef", lat, rd);
        else n_pass++;
        check_maxwait("gfx_priority_maxwait");
    endtask

    task automatic test_saturation_clear();
        logic [15:0] rd;
        int          lat;
        cpu_access(1'b0, 14'h0005, 16'h0, 2'b00, 300, rd, lat);
        check_maxwait("saturation_maxwait");
        stat_clr = 1'b1;
        next_cycle();
        stat_clr  = 1'b0;
        model_max = 0;
        check_maxwait("stat_clr_maxwait");
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] rd;
        int          lat;
        int          acks;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 14'h0123;
        next_cycle();
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cpu_ack !== 1'b0 || cpu_rddata !== 16'h0 || ram_wren !== 2'b00 ||
            ram_wrdata !== 16'h0 || ram_addr !== 14'h0 || stat_maxwait !== 8'h0)
            $display("FAIL reset_mid_read_outputs ack=%b rd=%h wren=%b wd=%h addr=%h max=%0d required all zero",
                     cpu_ack, cpu_rddata, ram_wren, ram_wrdata, ram_addr, stat_maxwait);
        else n_pass++;
        acks = 0;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            @(negedge clk);
            if (cpu_ack) acks++;
        end
        next_cycle();
        reset_n = 1'b1;
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cpu_ack) acks++;
            next_cycle();
        end
        n_checks++;
        if (acks !== 0) $display("FAIL reset_dropped_ack got=%0d acks expected=0", acks);
        else n_pass++;
        model_max = 0;
        pend      = 1'b0;
        cpu_access(1'b0, 14'h0123, 16'h0, 2'b00, 0, rd, lat);
        n_checks++;
        if (lat !== 2 || rd !== 16'hBEEF)
            $display("FAIL read_after_reset lat=%0d data=%h required lat=2 data=beef", lat, rd);
        else n_pass++;
        check_maxwait("read_after_reset_maxwait");
    endtask

    task automatic test_random();
        logic [15:0] rd;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            cpu_access(1'($urandom_range(0, 1)), 14'($urandom_range(0, 63)), 16'($urandom),
                       2'($urandom_range(1, 3)), -1, rd, lat);
        end
        check_maxwait("random_maxwait");
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        model_max   = 0;
        pend        = 1'b0;
        reset_n     = 1'b0;
        gfx_active  = 1'b0;
        gfx_vaddr   = '0;
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
        cpu_addr    = '0;
        cpu_wrdata  = '0;
        cpu_bytesel = '0;
        stat_clr    = 1'b0;
        pre_we      = 1'b0;
        pre_addr    = '0;
        pre_data    = '0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = 16'h0;
        next_cycle();
        pre_we = 1'b1;
        for (int i = 0; i < 65; i++) begin
            pre_addr = (i == 64) ? 14'h0123 : 14'(i);
            pre_data = (i == 64) ? 16'hBEEF : 16'($urandom);
            ref_mem[pre_addr] = pre_data;
            next_cycle();
        end
        pre_we = 1'b0;

        test_reset();
        test_idle_read();
        test_posted_write();
        test_back_to_back();
        test_gfx_priority();
        test_saturation_clear();
        test_reset_mid_read();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
